spi_rr_arbiter: RTL and testbench

//  Shares one spi_mnrch SPI master between NUM_REQ requesters (e.g. A2D sampler, inertial sensor).

---
 rtl/spi_rr_arbiter_pkg.sv | 16 +
 rtl/spi_rr_arbiter_if.sv | 28 ++
 rtl/spi_rr_arbiter_rr_pick.sv | 30 +++
 rtl/spi_rr_arbiter.sv | 101 ++++++++++
 tb/tb_spi_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_rr_arbiter_pkg.sv
// Shared types and constants for the SPI master round-robin arbiter.
// Latency: n/a. Backpressure: n/a.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int DEF_CMD_W = 16;
    // Timeout counter width; covers any TMO_CYC up to 65535.
    localparam int TMO_W     = 16;

endpackage

// File: rtl/spi_rr_arbiter_if.sv
// Requester and SPI-master side bus of the arbiter.
// Latency: n/a. Backpressure: requesters hold req until gnt.
interface spi_rr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int CMD_W   = 16
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CMD_W-1:0] req_cmd;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       rsp_vld;
    logic [CMD_W-1:0]         rsp_data;
    logic                     snd;
    logic [CMD_W-1:0]         cmd;
    logic                     done;
    logic [CMD_W-1:0]         resp;
    logic                     SS_n_mst;
    logic [NUM_REQ-1:0]       SS_n;

    modport slave (
        input  req, req_cmd, done, resp, SS_n_mst,
        output gnt, rsp_vld, rsp_data, snd, cmd, SS_n
    );

    modport master (
        output req, req_cmd, done, resp, SS_n_mst,
        input  gnt, rsp_vld, rsp_data, snd, cmd, SS_n
    );
endinterface

// File: rtl/spi_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching from ptr+1 cyclically.
// Latency: 0 cycles. Backpressure: none.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]                          req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  ptr,
    output logic [N-1:0]                          gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  idx,
    output logic                                  any
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 1; i <= N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = IW'(j);
                gnt[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_rr_arbiter.sv
// Shares one SPI master among NUM_REQ requesters with round-robin grant and SS_n steering.
// Latency: gnt/cmd one cycle after req seen in IDLE, snd next cycle, rsp_vld 2 cycles after done rise.
// Backpressure: requests wait (req held) until the current transaction finishes RESP.
module spi_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CMD_W   = spi_arb_pkg::DEF_CMD_W,
    parameter int TMO_CYC = 1023
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_rr_arbiter_if.slave bus,
    output logic            busy,
    output logic            tmo
);
    import spi_arb_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic               done_ff;
    logic               done_rise;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [CMD_W-1:0]   cmd_arr [NUM_REQ];

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cmd_arr[i] = bus.req_cmd[i*CMD_W +: CMD_W];
        end
    end

    assign done_rise = bus.done & ~done_ff;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= IW'(NUM_REQ - 1);
            owner        <= '0;
            done_ff      <= 1'b0;
            tmo_cnt      <= '0;
            tmo          <= 1'b0;
            bus.gnt      <= '0;
            bus.rsp_vld  <= '0;
            bus.rsp_data <= '0;
            bus.snd      <= 1'b0;
            bus.cmd      <= '0;
        end else begin
            done_ff     <= bus.done;
            bus.gnt     <= '0;
            bus.rsp_vld <= '0;
            bus.snd     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        bus.gnt <= pick_gnt;
                        bus.cmd <= cmd_arr[pick_idx];
                        owner   <= pick_idx;
                        ptr     <= pick_idx;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.snd <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // The master cannot be aborted, so a timeout only flags and keeps waiting.
                    if (tmo_cnt != TMO_W'(TMO_CYC - 1)) tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_cnt == TMO_W'(TMO_CYC - 2)) tmo <= 1'b1;
                    if (done_rise) state <= RESP;
                end
                RESP: begin
                    bus.rsp_data <= bus.resp;
                    bus.rsp_vld  <= NUM_REQ'(1) << owner;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // busy is low between owners, so steering never glitches across a change of owner.
    always_comb begin
        bus.SS_n = '1;
        if (busy) bus.SS_n[owner] = bus.SS_n_mst;
    end
endmodule

// File: tb/tb_spi_rr_arbiter.sv
// Scoreboard bench for spi_rr_arbiter with a behavioural SPI master and two slave models.
module tb_spi_rr_arbiter;
    localparam int N     = 2;
    localparam int W     = 16;
    localparam int TMO   = 64;
    localparam int FRAME = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic busy;
    logic tmo;

    spi_rr_arbiter_if #(.NUM_REQ(N), .CMD_W(W)) bus ();

    spi_rr_arbiter #(.NUM_REQ(N), .CMD_W(W), .TMO_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .tmo   (tmo)
    );

    logic         r0 = 1'b0;
    logic         r1 = 1'b0;
    logic [W-1:0] c0 = '0;
    logic [W-1:0] c1 = '0;
    logic         m_done = 1'b0;
    logic         m_ss   = 1'b1;
    logic [W-1:0] m_resp = '0;
    bit           stub   = 1'b0;

    assign bus.req      = {r1, r0};
    assign bus.req_cmd  = {c1, c0};
    assign bus.done     = m_done;
    assign bus.resp     = m_resp;
    assign bus.SS_n_mst = m_ss;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t         rsp_q[$];
    int           gnt_q[$];
    int           total  = 0;
    int           passed = 0;
    int           cyc    = 0;
    int           gnt_cnt[N];
    int           gnt_cyc[N];
    int           rsp_cyc[N];
    logic [N-1:0] ss_seen = '1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // SPI master plus slaves: slave0 returns ~byteswap(cmd), slave1 the same xor 16'h0100.
    initial begin
        logic [W-1:0] cmd_l;
        forever begin
            @(negedge clk);
            if (rst_n && bus.snd) begin
                cmd_l = bus.cmd;
                @(posedge clk);
                #1;
                m_done = 1'b0;
                m_ss   = 1'b0;
                if (!stub) begin
                    repeat (FRAME / 2) @(posedge clk);
                    #1 ss_seen = bus.SS_n;
                    repeat (FRAME / 2) @(posedge clk);
                    #1;
                    case (ss_seen)
                        2'b10:   m_resp = ~{cmd_l[7:0], cmd_l[15:8]};
                        2'b01:   m_resp = ~{cmd_l[7:0], cmd_l[15:8]} ^ 16'h0100;
                        default: m_resp = 16'hDEAD;
                    endcase
                    m_ss   = 1'b1;
                    m_done = 1'b1;
                end
            end
        end
    end

    initial begin
        exp_t e;
        int   g;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.gnt != '0) begin
                    for (int i = 0; i < N; i++) begin
                        if (bus.gnt[i]) begin
                            gnt_cnt[i]++;
                            gnt_cyc[i] = cyc;
                        end
                    end
                    if (gnt_q.size() == 0) check_eq("gnt_unexpected", 32'(bus.gnt), 0);
                    else begin
                        g = gnt_q.pop_front();
                        check_eq("gnt_order", 32'(bus.gnt), 32'(1 << g));
                    end
                end
                if (bus.rsp_vld != '0) begin
                    for (int i = 0; i < N; i++) if (bus.rsp_vld[i]) rsp_cyc[i] = cyc;
                    if (rsp_q.size() == 0) check_eq("rsp_unexpected", 32'(bus.rsp_vld), 0);
                    else begin
                        e = rsp_q.pop_front();
                        check_eq("rsp_vld_owner", 32'(bus.rsp_vld), 32'(1 << e.idx));
                        check_eq("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    end
                end
            end
        end
    end

    task automatic agent(int i, logic [W-1:0] c);
        int n;
        n = 0;
        if (i == 0) begin c0 = c; r0 = 1'b1; end
        else        begin c1 = c; r1 = 1'b1; end
        do begin
            @(negedge clk);
            n++;
        end while (!bus.gnt[i] && n < 2000);
        if (n >= 2000) check_eq("gnt_wait", 32'(bus.gnt[i]), 1);
        if (i == 0) r0 = 1'b0;
        else        r1 = 1'b0;
    endtask

    task automatic wait_snd();
        int n;
        n = 0;
        while (!bus.snd && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("snd_wait", 32'(bus.snd), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || gnt_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(rsp_q.size() + gnt_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        foreach (gnt_cnt[i]) begin gnt_cnt[i] = 0; gnt_cyc[i] = 0; rsp_cyc[i] = 0; end

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_gnt", 32'(bus.gnt), 0);
        check_eq("rst_rsp_vld", 32'(bus.rsp_vld), 0);
        check_eq("rst_rsp_data", 32'(bus.rsp_data), 0);
        check_eq("rst_cmd", 32'(bus.cmd), 0);
        check_eq("rst_SS_n", 32'(bus.SS_n), 32'h3);
        rst_n = 1'b1;

        // Idle with no requests for 100 cycles
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.SS_n != 2'b11 || bus.snd || busy || tmo) bad = 1'b1;
        end
        check_eq("idle_quiet", 32'(bad), 0);

        // Single transaction from requester 0
        gnt_q.push_back(0);
        rsp_q.push_back('{0, 16'h3C5A});
        agent(0, 16'hA5C3);
        drain();
        check_eq("t2_gnt0_count", 32'(gnt_cnt[0]), 1);
        check_eq("t2_SS_n_during", 32'(ss_seen), 32'h2);
        check_eq("t2_rsp_data_held", 32'(bus.rsp_data), 32'h3C5A);

        // Requester 1 arrives while requester 0 is in WAIT
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        rsp_q.push_back('{0, 16'hEEEE});
        rsp_q.push_back('{1, 16'hDCDD});
        fork
            agent(0, 16'h1111);
            begin
                wait_snd();
                repeat (3) @(negedge clk);
                agent(1, 16'h2222);
            end
        join
        drain();
        check_eq("t4_gnt1_after_rsp0", 32'(gnt_cyc[1] - rsp_cyc[0]), 1);
        check_eq("t4_SS_n_slave1", 32'(ss_seen), 32'h1);

        // Both held: strict rotation 0,1,0,1
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        rsp_q.push_back('{0, 16'hEEEE});
        rsp_q.push_back('{1, 16'hDCDD});
        rsp_q.push_back('{0, 16'hEEEE});
        rsp_q.push_back('{1, 16'hDCDD});
        fork
            begin agent(0, 16'h1111); agent(0, 16'h1111); end
            begin agent(1, 16'h2222); agent(1, 16'h2222); end
        join
        drain();
        check_eq("t3_gnt0_total", 32'(gnt_cnt[0]), 4);
        check_eq("t3_gnt1_total", 32'(gnt_cnt[1]), 3);

        // Timeout: master never completes
        stub = 1'b1;
        gnt_q.push_back(0);
        agent(0, 16'h0F0F);
        wait_snd();
        repeat (59) @(negedge clk);
        check_eq("t5_tmo_early", 32'(tmo), 0);
        repeat (6) @(negedge clk);
        check_eq("t5_tmo_set", 32'(tmo), 1);
        repeat (50) @(negedge clk);
        check_eq("t5_tmo_sticky", 32'(tmo), 1);
        check_eq("t5_busy", 32'(busy), 1);
        check_eq("t5_SS_n_owner", 32'(bus.SS_n), 32'h2);

        // Asynchronous reset mid-WAIT
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_SS_n_async", 32'(bus.SS_n), 32'h3);
        check_eq("t6_busy", 32'(busy), 0);
        check_eq("t6_tmo", 32'(tmo), 0);
        check_eq("t6_rsp_data", 32'(bus.rsp_data), 0);
        stub   = 1'b0;
        m_ss   = 1'b1;
        m_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gnt_q.push_back(1);
        rsp_q.push_back('{1, 16'hCAED});
        agent(1, 16'h1234);
        drain();
        check_eq("t6_SS_n_slave1", 32'(ss_seen), 32'h1);
        check_eq("t6_tmo_clear", 32'(tmo), 0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
